riscv_alu: RTL and testbench

//  RV32I integer ALU of the processor datapath. Computes the arithmetic, logic and shift

---
 rtl/riscv_alu.sv | 121 ++++++++++++
 tb/tb_riscv_alu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_alu.sv
// ---------------------------------------------------------------------------
// riscv_alu
//
// Integer ALU for the RV32I execute stage. It produces the arithmetic, logic
// and shift result, along with the branch-compare flag, from two 32-bit
// operands and a 5-bit opcode.
//
// Result and Flag are purely combinational, so execute and branch logic can
// use them in the same cycle. Registered copies (Result_q / Flag_q) are taken
// on every rising clock edge and feed pipeline and debug consumers.
//
// Ports
//   clk_i     in   1   clock, rising edge active
//   rst_ni    in   1   asynchronous active-low reset (registered outputs only)
//   A         in   32  operand A
//   B         in   32  operand B; B[4:0] is the shift amount for shift ops
//   ALUOp     in   5   operation code
//   Result    out  32  combinational result
//   Flag      out  1   combinational compare flag
//   Result_q  out  32  Result delayed by one clock
//   Flag_q    out  1   Flag delayed by one clock
// ---------------------------------------------------------------------------
module riscv_alu (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [4:0]  ALUOp,
  output logic [31:0] Result,
  output logic        Flag,
  output logic [31:0] Result_q,
  output logic        Flag_q
);

  // Operation encoding. Codes with bits [4:3] == 2'b11 are the branch compares.
  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SLL  = 5'b00001,
    OP_SLTS = 5'b00010,
    OP_SLTU = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_SRL  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_AND  = 5'b00111,
    OP_SUB  = 5'b01000,
    OP_SRA  = 5'b01101,
    OP_EQ   = 5'b11000,
    OP_NE   = 5'b11001,
    OP_LTS  = 5'b11100,
    OP_GES  = 5'b11101,
    OP_LTU  = 5'b11110,
    OP_GEU  = 5'b11111
  } aluOp_e;

  logic [4:0]  w_shamt;
  logic        w_eq;
  logic        w_lts;
  logic        w_ltu;
  logic        w_flag;
  logic [31:0] w_result;

  // Only the low five bits of B set the shift distance; the upper bits are
  // ignored, matching the RV32I shift semantics.
  assign w_shamt = B[4:0];

  // These shared comparators serve both the SLT-style results and the branch
  // flags, so each comparison is built only once.
  assign w_eq  = (A == B);
  assign w_lts = ($signed(A) < $signed(B));
  assign w_ltu = (A < B);

  // Main operation decode. Defaults come first, so any unlisted opcode
  // returns zero on both outputs and no X can leak onto the datapath.
  always_comb begin
    w_result = 32'd0;
    w_flag   = 1'b0;
    case (ALUOp)
      OP_ADD:  w_result = A + B;
      OP_SUB:  w_result = A - B;
      OP_SLL:  w_result = A << w_shamt;
      OP_SRL:  w_result = A >> w_shamt;
      OP_SRA:  w_result = $unsigned($signed(A) >>> w_shamt);
      OP_SLTS: w_result = {31'd0, w_lts};
      OP_SLTU: w_result = {31'd0, w_ltu};
      OP_XOR:  w_result = A ^ B;
      OP_OR:   w_result = A | B;
      OP_AND:  w_result = A & B;
      OP_EQ:   w_flag   = w_eq;
      OP_NE:   w_flag   = ~w_eq;
      OP_LTS:  w_flag   = w_lts;
      OP_GES:  w_flag   = ~w_lts;
      OP_LTU:  w_flag   = w_ltu;
      OP_GEU:  w_flag   = ~w_ltu;
      default: begin
        w_result = 32'd0;
        w_flag   = 1'b0;
      end
    endcase
    // A compare opcode also reports its flag as a 0/1 result word.
    if (ALUOp[4:3] == 2'b11) begin
      w_result = {31'd0, w_flag};
    end
  end

  assign Result = w_result;
  assign Flag   = w_flag;

  // Registered copies have no enable and capture every edge. Reset clears
  // them at once and holds them at zero; the combinational path keeps
  // tracking its inputs throughout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      Result_q <= 32'd0;
      Flag_q   <= 1'b0;
    end else begin
      Result_q <= w_result;
      Flag_q   <= w_flag;
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// ---------------------------------------------------------------------------
// tb_riscv_alu
//
// Self-checking bench for riscv_alu. It applies directed cases for each
// opcode, covers the reset and registered-output behaviour, and then runs
// randomized operations against a behavioural arithmetic model.
// ---------------------------------------------------------------------------
module tb_riscv_alu;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SLL  = 5'b00001;
  localparam logic [4:0] SLTS = 5'b00010;
  localparam logic [4:0] SLTU = 5'b00011;
  localparam logic [4:0] XOR  = 5'b00100;
  localparam logic [4:0] SRL  = 5'b00101;
  localparam logic [4:0] OR   = 5'b00110;
  localparam logic [4:0] AND  = 5'b00111;
  localparam logic [4:0] SUB  = 5'b01000;
  localparam logic [4:0] SRA  = 5'b01101;
  localparam logic [4:0] EQ   = 5'b11000;
  localparam logic [4:0] NE   = 5'b11001;
  localparam logic [4:0] LTS  = 5'b11100;
  localparam logic [4:0] GES  = 5'b11101;
  localparam logic [4:0] LTU  = 5'b11110;
  localparam logic [4:0] GEU  = 5'b11111;

  logic        clk_i;
  logic        rst_ni;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ALUOp;
  logic [31:0] Result;
  logic        Flag;
  logic [31:0] Result_q;
  logic        Flag_q;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  riscv_alu dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .A        (A),
    .B        (B),
    .ALUOp    (ALUOp),
    .Result   (Result),
    .Flag     (Flag),
    .Result_q (Result_q),
    .Flag_q   (Flag_q)
  );

  // Free-running clock with a period of 10.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Behavioural reference model. It works from the instruction semantics
  // using wide integer arithmetic: shifts are repeated multiply/divide by
  // two, and compares use 64-bit signed and unsigned values.
  function automatic void refModel(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] res,
                                   output logic flag);
    longint sa, sb, ua, ub, acc;
    int     sh;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    sh  = int'(b % 32);
    res = 32'd0;
    flag = 1'b0;
    case (op)
      ADD:  res = 32'((ua + ub) % 64'h1_0000_0000);
      SUB:  res = 32'((ua - ub + 64'h1_0000_0000) % 64'h1_0000_0000);
      SLL:  begin
              acc = ua;
              for (int i = 0; i < sh; i++) acc = (acc * 2) % 64'h1_0000_0000;
              res = 32'(acc);
            end
      SRL:  begin
              acc = ua;
              for (int i = 0; i < sh; i++) acc = acc / 2;
              res = 32'(acc);
            end
      SRA:  begin
              acc = sa;
              // Floor division by two, so negative values round toward -inf.
              for (int i = 0; i < sh; i++) acc = (acc >= 0) ? acc / 2 : (acc - 1) / 2;
              res = 32'(acc);
            end
      SLTS: res = (sa < sb) ? 32'd1 : 32'd0;
      SLTU: res = (ua < ub) ? 32'd1 : 32'd0;
      XOR:  res = a ^ b;
      OR:   res = a | b;
      AND:  res = a & b;
      EQ:   flag = (ua == ub);
      NE:   flag = (ua != ub);
      LTS:  flag = (sa < sb);
      GES:  flag = (sa >= sb);
      LTU:  flag = (ua < ub);
      GEU:  flag = (ua >= ub);
      default: begin
        res  = 32'd0;
        flag = 1'b0;
      end
    endcase
    if (op inside {EQ, NE, LTS, GES, LTU, GEU}) res = flag ? 32'd1 : 32'd0;
  endfunction

  // Inputs change on the falling edge and settle before the outputs are
  // sampled, which keeps every sample away from the active edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge clk_i);
    ALUOp = op;
    A     = a;
    B     = b;
    #1;
  endtask

  // Checks the combinational outputs.
  task automatic checkOutput(input string tag, input logic [31:0] expRes,
                             input logic expFlag);
    checkCount++;
    assert (Result === expRes) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s Result: observed %h expected %h", tag, Result, expRes);
    end
    checkCount++;
    assert (Flag === expFlag) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s Flag: observed %b expected %b", tag, Flag, expFlag);
    end
  endtask

  // Checks the registered outputs.
  task automatic checkReg(input string tag, input logic [31:0] expRes,
                          input logic expFlag);
    checkCount++;
    assert (Result_q === expRes) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s Result_q: observed %h expected %h", tag, Result_q, expRes);
    end
    checkCount++;
    assert (Flag_q === expFlag) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s Flag_q: observed %b expected %b", tag, Flag_q, expFlag);
    end
  endtask

  // Waits for the next rising edge and samples just after it.
  task automatic clockEdge();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b, expRes;
    logic        expFlag;
    logic [4:0]  legalOps [16];

    legalOps = '{ADD, SLL, SLTS, SLTU, XOR, SRL, OR, AND,
                 SUB, SRA, EQ, NE, LTS, GES, LTU, GEU};

    rst_ni = 1'b0;
    A = 32'd0;
    B = 32'd0;
    ALUOp = ADD;
    #1;
    checkReg("resetInitial", 32'd0, 1'b0);

    // While reset is held, the combinational path still works and the
    // registers hold zero across clock edges.
    applyStimulus(ADD, 32'd1, 32'd2);
    checkOutput("addDuringReset", 32'd3, 1'b0);
    clockEdge();
    checkReg("holdInReset", 32'd0, 1'b0);

    // Release reset between edges; the first edge after release captures.
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkReg("afterReleaseBeforeEdge", 32'd0, 1'b0);
    clockEdge();
    checkReg("firstCapture", 32'd3, 1'b0);

    // Directed cases for each opcode.
    applyStimulus(ADD, 32'hFFFF_FFFF, 32'd1);   checkOutput("addWrap", 32'd0, 1'b0);
    applyStimulus(AND, 32'd3, 32'd1);           checkOutput("and", 32'd1, 1'b0);
    applyStimulus(OR, 32'd4, 32'd2);            checkOutput("or", 32'd6, 1'b0);
    applyStimulus(XOR, 32'd6, 32'd3);           checkOutput("xor", 32'd5, 1'b0);
    applyStimulus(SUB, 32'd4, 32'd2);           checkOutput("sub", 32'd2, 1'b0);
    applyStimulus(SUB, 32'd0, 32'd1);           checkOutput("subWrap", 32'hFFFF_FFFF, 1'b0);
    applyStimulus(NE, 32'd3, 32'd3);            checkOutput("neEqual3", 32'd0, 1'b0);
    applyStimulus(NE, 32'd1, 32'd1);            checkOutput("neEqual1", 32'd0, 1'b0);
    applyStimulus(NE, 32'd0, 32'd1);            checkOutput("neDiff", 32'd1, 1'b1);
    applyStimulus(LTS, 32'hFFFF_FFFF, 32'd1);   checkOutput("ltsNeg", 32'd1, 1'b1);
    applyStimulus(LTU, 32'hFFFF_FFFF, 32'd1);   checkOutput("ltuBig", 32'd0, 1'b0);
    applyStimulus(GES, 32'hFFFF_FFFF, 32'd1);   checkOutput("gesNeg", 32'd0, 1'b0);
    applyStimulus(GEU, 32'h1234_5678, 32'h1234_5678); checkOutput("geuEqual", 32'd1, 1'b1);
    applyStimulus(EQ, 32'hDEAD_BEEF, 32'hDEAD_BEEF);   checkOutput("eqEqual", 32'd1, 1'b1);
    applyStimulus(SLTS, 32'h8000_0000, 32'd0);  checkOutput("sltsNeg", 32'd1, 1'b0);
    applyStimulus(SLTU, 32'h8000_0000, 32'd0);  checkOutput("sltuBig", 32'd0, 1'b0);
    applyStimulus(SRA, 32'h8000_0000, 32'h0000_0021); checkOutput("sraShamtMask", 32'hC000_0000, 1'b0);
    applyStimulus(SRL, 32'h8000_0000, 32'h0000_0021); checkOutput("srlShamtMask", 32'h4000_0000, 1'b0);
    applyStimulus(SLL, 32'd1, 32'd31);          checkOutput("sll31", 32'h8000_0000, 1'b0);
    applyStimulus(5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF); checkOutput("illegalOp", 32'd0, 1'b0);

    // Put a 1 on both registered outputs, then drop reset between edges.
    // The registers must clear at once while the comb path keeps its value.
    applyStimulus(EQ, 32'd7, 32'd7);
    clockEdge();
    checkReg("captureEq", 32'd1, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkReg("asyncResetClears", 32'd0, 1'b0);
    checkOutput("combDuringReset", 32'd1, 1'b1);
    applyStimulus(ADD, 32'd5, 32'd6);
    checkOutput("combTracksInReset", 32'd11, 1'b0);
    clockEdge();
    checkReg("holdAfterMidReset", 32'd0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    clockEdge();
    checkReg("captureAfterRelease", 32'd11, 1'b0);

    // Randomized operations. Each one is checked on the comb outputs and
    // again on the registered outputs after the next edge. About one in
    // eight uses a random 5-bit opcode, so illegal codes are also covered.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(7) == 0) op = 5'($urandom_range(31));
      else                        op = legalOps[$urandom_range(15)];
      a = $urandom;
      case ($urandom_range(3))
        0:       b = a;
        1:       b = {$urandom_range(1) == 1 ? 27'h7FF_FFFF : 27'd0, 5'($urandom_range(31))};
        default: b = $urandom;
      endcase
      refModel(op, a, b, expRes, expFlag);
      applyStimulus(op, a, b);
      checkOutput($sformatf("rand%0d op%b", n, op), expRes, expFlag);
      clockEdge();
      checkReg($sformatf("randReg%0d op%b", n, op), expRes, expFlag);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
